// File: rtl/clock_hms_gen.sv
// clock_hms_gen: hours/minutes/seconds clock with a field-select set FSM,
// a blinking edit field, four active-low 7-segment digits (gfedcba) and
// binary LED outputs. Page 0 shows HH:MM and page 1 shows MM:SS.
// Optional feature macro: CLOCK_HMS_ALARM_EN adds an alarm time (two more
// set modes) and a one-bit alarm output.
module clock_hms_gen #(
    parameter int CLK_HZ   = 100000000,
    parameter int SIM_DIV  = 100,
    parameter int HOUR_MAX = 24,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnr,
    input  logic       btnl,
    input  logic       btnu,
    input  logic       en4sim,
    input  logic       mask4sim,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0,
    output logic [4:0] hour_led,
    output logic [5:0] min_led,
    output logic [5:0] sec_led,
    output logic [2:0] mode
`ifdef CLOCK_HMS_ALARM_EN
    ,
    output logic       alarm
`endif
);

    localparam int CW = $clog2(CLK_HZ);
    localparam logic [CW-1:0] DIV_REAL_M1  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] DIV_SIM_M1   = CW'(SIM_DIV - 1);
    localparam logic [CW-1:0] HALF_REAL_M1 = CW'(CLK_HZ / (2 * BLINK_HZ) - 1);
    localparam logic [CW-1:0] HALF_SIM_M1  = CW'(SIM_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [4:0]    HOUR_LAST    = 5'(HOUR_MAX - 1);

    typedef enum logic [2:0] {
        M_RUN      = 3'd0,
        M_SET_SEC  = 3'd1,
        M_SET_MIN  = 3'd2,
        M_SET_HOUR = 3'd3,
        M_ALM_HOUR = 3'd4,
        M_ALM_MIN  = 3'd5
    } mode_e;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    function automatic logic [5:0] inc60(input logic [5:0] v);
        if (v >= 6'd59) begin
            inc60 = 6'd0;
        end else begin
            inc60 = v + 6'd1;
        end
    endfunction

    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        if (v >= HOUR_LAST) begin
            inc_hour = 5'd0;
        end else begin
            inc_hour = v + 5'd1;
        end
    endfunction

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        tens_of = 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        ones_of = 4'(v % 6'd10);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            M_RUN:      next_mode = M_SET_SEC;
            M_SET_SEC:  next_mode = M_SET_MIN;
            M_SET_MIN:  next_mode = M_SET_HOUR;
`ifdef CLOCK_HMS_ALARM_EN
            M_SET_HOUR: next_mode = M_ALM_HOUR;
            M_ALM_HOUR: next_mode = M_ALM_MIN;
`else
            M_SET_HOUR: next_mode = M_RUN;
`endif
            default:    next_mode = M_RUN;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    mode_e          mode_q, mode_d;
    logic           page_q, page_d;
    logic           blink_q, blink_d;
    logic [CW-1:0]  blink_cnt_q, blink_cnt_d;
    logic [CW-1:0]  presc_q, presc_d;
    logic [4:0]     hour_q, hour_d;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
`ifdef CLOCK_HMS_ALARM_EN
    logic [4:0]     alm_hour_q, alm_hour_d;
    logic [5:0]     alm_min_q, alm_min_d;
    logic           alarm_q, alarm_d;
`endif

    logic [CW-1:0]  div_m1_s;
    logic [CW-1:0]  half_m1_s;
    logic           tick_s;

    // Registered outputs
    logic [6:0]     disp3_q, disp2_q, disp1_q, disp0_q;
    logic [6:0]     disp3_d, disp2_d, disp1_d, disp0_d;
    logic [4:0]     hour_led_q, hour_led_d;
    logic [5:0]     min_led_q, min_led_d;
    logic [5:0]     sec_led_q, sec_led_d;

    // Display selection
    logic           page_s;
    logic           blank_s;
    logic [5:0]     left_val_s, right_val_s;
    logic           left_blank_s, right_blank_s;

    // Clock state register: time counters, prescaler, mode, page and blink.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= M_RUN;
            page_q      <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            presc_q     <= '0;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
`ifdef CLOCK_HMS_ALARM_EN
            alm_hour_q  <= 5'd0;
            alm_min_q   <= 6'd0;
            alarm_q     <= 1'b0;
`endif
        end else begin
            mode_q      <= mode_d;
            page_q      <= page_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            presc_q     <= presc_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
`ifdef CLOCK_HMS_ALARM_EN
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
            alarm_q     <= alarm_d;
`endif
        end
    end

    // Next state: prescaler/tick, time advance, blink phase and button actions.
    always_comb begin
        mode_d      = mode_q;
        page_d      = page_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        presc_d     = presc_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        tick_s      = 1'b0;
`ifdef CLOCK_HMS_ALARM_EN
        alm_hour_d  = alm_hour_q;
        alm_min_d   = alm_min_q;
        alarm_d     = alarm_q;
`endif
        div_m1_s    = en4sim ? DIV_SIM_M1  : DIV_REAL_M1;
        half_m1_s   = en4sim ? HALF_SIM_M1 : HALF_REAL_M1;

        // Prescaler runs only in RUN; blink phase runs only while editing.
        // The >= also recovers if en4sim shrinks the divider mid-count.
        if (mode_q == M_RUN) begin
            if (presc_q >= div_m1_s) begin
                tick_s  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + CNT_ONE;
            end
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else begin
            presc_d = '0;
            if (blink_cnt_q >= half_m1_s) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_ONE;
            end
        end

        // Seconds tick with carry chain sec -> min -> hour.
        if (tick_s) begin
            if (sec_q >= 6'd59) begin
                sec_d = 6'd0;
                if (min_q >= 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = inc_hour(hour_q);
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            sec_d = sec_q;
        end

        // Buttons, highest priority first; a tick coinciding with btnl still lands.
        if (btnl) begin
            mode_d      = next_mode(mode_q);
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (btnu) begin
            case (mode_q)
                M_SET_SEC:  sec_d      = inc60(sec_q);
                M_SET_MIN:  min_d      = inc60(min_q);
                M_SET_HOUR: hour_d     = inc_hour(hour_q);
`ifdef CLOCK_HMS_ALARM_EN
                M_ALM_HOUR: alm_hour_d = inc_hour(alm_hour_q);
                M_ALM_MIN:  alm_min_d  = inc60(alm_min_q);
`endif
                default:    mode_d     = mode_q;
            endcase
        end else if (btnr) begin
            case (mode_q)
                M_RUN:      page_d     = ~page_q;
                M_SET_SEC:  sec_d      = 6'd0;
                M_SET_MIN:  min_d      = 6'd0;
                M_SET_HOUR: hour_d     = 5'd0;
`ifdef CLOCK_HMS_ALARM_EN
                M_ALM_HOUR: alm_hour_d = 5'd0;
                M_ALM_MIN:  alm_min_d  = 6'd0;
`endif
                default:    mode_d     = mode_q;
            endcase
        end else begin
            mode_d = mode_q;
        end

`ifdef CLOCK_HMS_ALARM_EN
        // Alarm fires when the minute rolls over onto the alarm time and is
        // dismissed by any button or by the following minute change.
        if (btnl || btnu || btnr) begin
            alarm_d = 1'b0;
        end else if (tick_s && (sec_d == 6'd0) && (min_d == alm_min_q) &&
                     (hour_d == alm_hour_q)) begin
            alarm_d = 1'b1;
        end else if (min_d != min_q) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
`endif
    end

    // Display content: effective page, field values and blink blanking.
    always_comb begin
        blank_s       = blink_q & ~mask4sim;
        page_s        = page_q;
        left_blank_s  = 1'b0;
        right_blank_s = 1'b0;
        case (mode_q)
            M_SET_SEC:  page_s = 1'b1;
            M_SET_HOUR: page_s = 1'b0;
`ifdef CLOCK_HMS_ALARM_EN
            M_ALM_HOUR: page_s = 1'b0;
            M_ALM_MIN:  page_s = 1'b0;
`endif
            default:    page_s = page_q;
        endcase
        if (page_s) begin
            left_val_s  = min_q;
            right_val_s = sec_q;
        end else begin
            left_val_s  = {1'b0, hour_q};
            right_val_s = min_q;
        end
        case (mode_q)
            M_SET_SEC:  right_blank_s = blank_s;
            M_SET_MIN: begin
                if (page_s) begin
                    left_blank_s = blank_s;
                end else begin
                    right_blank_s = blank_s;
                end
            end
            M_SET_HOUR: left_blank_s = blank_s;
`ifdef CLOCK_HMS_ALARM_EN
            M_ALM_HOUR: begin
                left_val_s   = {1'b0, alm_hour_q};
                right_val_s  = alm_min_q;
                left_blank_s = blank_s;
            end
            M_ALM_MIN: begin
                left_val_s    = {1'b0, alm_hour_q};
                right_val_s   = alm_min_q;
                right_blank_s = blank_s;
            end
`endif
            default: begin
                left_blank_s  = 1'b0;
                right_blank_s = 1'b0;
            end
        endcase
        disp3_d    = left_blank_s  ? 7'h7F : seg7(tens_of(left_val_s));
        disp2_d    = left_blank_s  ? 7'h7F : seg7(ones_of(left_val_s));
        disp1_d    = right_blank_s ? 7'h7F : seg7(tens_of(right_val_s));
        disp0_d    = right_blank_s ? 7'h7F : seg7(ones_of(right_val_s));
        hour_led_d = (blank_s && (mode_q == M_SET_HOUR)) ? 5'd0 : hour_q;
        min_led_d  = (blank_s && (mode_q == M_SET_MIN))  ? 6'd0 : min_q;
        sec_led_d  = (blank_s && (mode_q == M_SET_SEC))  ? 6'd0 : sec_q;
    end

    // Output registers: display and LEDs lag the counters by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp3_q    <= 7'h40;
            disp2_q    <= 7'h40;
            disp1_q    <= 7'h40;
            disp0_q    <= 7'h40;
            hour_led_q <= 5'd0;
            min_led_q  <= 6'd0;
            sec_led_q  <= 6'd0;
        end else begin
            disp3_q    <= disp3_d;
            disp2_q    <= disp2_d;
            disp1_q    <= disp1_d;
            disp0_q    <= disp0_d;
            hour_led_q <= hour_led_d;
            min_led_q  <= min_led_d;
            sec_led_q  <= sec_led_d;
        end
    end

    assign disp3    = disp3_q;
    assign disp2    = disp2_q;
    assign disp1    = disp1_q;
    assign disp0    = disp0_q;
    assign hour_led = hour_led_q;
    assign min_led  = min_led_q;
    assign sec_led  = sec_led_q;
    assign mode     = mode_q;
`ifdef CLOCK_HMS_ALARM_EN
    assign alarm    = alarm_q;
`endif

endmodule

// File: tb/tb_clock_hms_gen.sv
// Testbench for clock_hms_gen: reference model works on total seconds of day
// and elapsed cycle counts; randomized button traffic plus directed scenarios.
module tb_clock_hms_gen;

    localparam int CLK_HZ   = 100000000;
    localparam int SIM_DIV  = 100;
    localparam int HOUR_MAX = 24;
    localparam int BLINK_HZ = 2;
    localparam int HALF     = SIM_DIV / 2;
    localparam int TOT      = HOUR_MAX * 3600;
`ifdef CLOCK_HMS_ALARM_EN
    localparam int NM = 6;
    localparam int OW = 49;
`else
    localparam int NM = 4;
    localparam int OW = 48;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btnr = 1'b0, btnl = 1'b0, btnu = 1'b0;
    logic en4sim = 1'b1, mask4sim = 1'b0;
    logic [6:0] disp3, disp2, disp1, disp0;
    logic [4:0] hour_led;
    logic [5:0] min_led, sec_led;
    logic [2:0] mode;
`ifdef CLOCK_HMS_ALARM_EN
    logic alarm;
`endif

    always #5 clk = ~clk;

    clock_hms_gen #(
        .CLK_HZ(CLK_HZ), .SIM_DIV(SIM_DIV), .HOUR_MAX(HOUR_MAX), .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk(clk), .rst(rst), .btnr(btnr), .btnl(btnl), .btnu(btnu),
        .en4sim(en4sim), .mask4sim(mask4sim),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .hour_led(hour_led), .min_led(min_led), .sec_led(sec_led),
        .mode(mode)
`ifdef CLOCK_HMS_ALARM_EN
        , .alarm(alarm)
`endif
    );

    logic [OW-1:0] obs_w;
`ifdef CLOCK_HMS_ALARM_EN
    assign obs_w = {disp3, disp2, disp1, disp0, hour_led, min_led, sec_led, mode, alarm};
`else
    assign obs_w = {disp3, disp2, disp1, disp0, hour_led, min_led, sec_led, mode};
`endif

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state
    int m_t = 0;      // seconds since midnight
    int m_mode = 0;
    int m_page = 0;
    int m_run = 0;    // cycles spent in RUN since entry
    int m_set = 0;    // cycles spent in current set mode
`ifdef CLOCK_HMS_ALARM_EN
    int   m_ah = 0, m_am = 0;
    logic m_alarm = 1'b0;
`endif
    logic [6:0] e_d3, e_d2, e_d1, e_d0;
    logic [4:0] e_hl;
    logic [5:0] e_ml, e_sl;
    logic [OW-1:0] exp_w;

    int total = 0;
    int bad = 0;

    task automatic model_step();
        int h, mi, s, pg, lv, rv, nmi;
        bit blank, lb, rb, tick;
        h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
        if (!rst) begin
            e_d3 = 7'h40; e_d2 = 7'h40; e_d1 = 7'h40; e_d0 = 7'h40;
            e_hl = 5'd0; e_ml = 6'd0; e_sl = 6'd0;
            m_t = 0; m_mode = 0; m_page = 0; m_run = 0; m_set = 0;
`ifdef CLOCK_HMS_ALARM_EN
            m_ah = 0; m_am = 0; m_alarm = 1'b0;
`endif
        end else begin
            pg = (m_mode == 1) ? 1 : ((m_mode == 0 || m_mode == 2) ? m_page : 0);
            blank = (m_mode != 0) && (((m_set / HALF) % 2) == 1) && !mask4sim;
`ifdef CLOCK_HMS_ALARM_EN
            if (m_mode >= 4) begin lv = m_ah; rv = m_am; end
            else
`endif
            if (pg == 1) begin lv = mi; rv = s; end
            else begin lv = h; rv = mi; end
            lb = blank && (m_mode == 3 || m_mode == 4 || (m_mode == 2 && pg == 1));
            rb = blank && (m_mode == 1 || m_mode == 5 || (m_mode == 2 && pg == 0));
            e_d3 = lb ? 7'h7F : seg_tab[lv / 10];
            e_d2 = lb ? 7'h7F : seg_tab[lv % 10];
            e_d1 = rb ? 7'h7F : seg_tab[rv / 10];
            e_d0 = rb ? 7'h7F : seg_tab[rv % 10];
            e_hl = (blank && m_mode == 3) ? 5'd0 : 5'(h);
            e_ml = (blank && m_mode == 2) ? 6'd0 : 6'(mi);
            e_sl = (blank && m_mode == 1) ? 6'd0 : 6'(s);

            tick = (m_mode == 0) && ((m_run % SIM_DIV) == SIM_DIV - 1);
            if (m_mode == 0) m_run++;
            if (tick) m_t = (m_t + 1) % TOT;
            if (btnl) begin
                m_mode = (m_mode + 1) % NM; m_set = 0; m_run = 0;
            end else begin
                if (m_mode != 0) m_set++;
                if (btnu) begin
                    case (m_mode)
                        1: m_t = m_t - s + (s + 1) % 60;
                        2: m_t = m_t - mi * 60 + ((mi + 1) % 60) * 60;
                        3: m_t = m_t - h * 3600 + ((h + 1) % HOUR_MAX) * 3600;
`ifdef CLOCK_HMS_ALARM_EN
                        4: m_ah = (m_ah + 1) % HOUR_MAX;
                        5: m_am = (m_am + 1) % 60;
`endif
                        default: ;
                    endcase
                end else if (btnr) begin
                    case (m_mode)
                        0: m_page = 1 - m_page;
                        1: m_t = m_t - s;
                        2: m_t = m_t - mi * 60;
                        3: m_t = m_t - h * 3600;
`ifdef CLOCK_HMS_ALARM_EN
                        4: m_ah = 0;
                        5: m_am = 0;
`endif
                        default: ;
                    endcase
                end
            end
            nmi = (m_t / 60) % 60;
`ifdef CLOCK_HMS_ALARM_EN
            if (btnl || btnu || btnr) m_alarm = 1'b0;
            else if (tick && (m_t % 60 == 0) && (nmi == m_am) && (m_t / 3600 == m_ah)) m_alarm = 1'b1;
            else if (nmi != mi) m_alarm = 1'b0;
`endif
        end
`ifdef CLOCK_HMS_ALARM_EN
        exp_w = {e_d3, e_d2, e_d1, e_d0, e_hl, e_ml, e_sl, 3'(m_mode), m_alarm};
`else
        exp_w = {e_d3, e_d2, e_d1, e_d0, e_hl, e_ml, e_sl, 3'(m_mode)};
`endif
    endtask

    // Advance n cycles; buttons are one-cycle pulses cleared after the first.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            btnl = 1'b0; btnu = 1'b0; btnr = 1'b0;
        end
    endtask

    task automatic press(input logic l, input logic u, input logic r);
        btnl = l; btnu = u; btnr = r;
        cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(3);
        total++;
        if (obs_w !== exp_w) begin bad++; $display("FAIL reset_state: got %h want %h", obs_w, exp_w); end
        total++;
        if ({disp3, disp2, disp1, disp0, hour_led, min_led, sec_led, mode} !== {7'h40, 7'h40, 7'h40, 7'h40, 5'd0, 6'd0, 6'd0, 3'd0}) begin
            bad++; $display("FAIL reset_const: got %h %h %h %h %0d %0d %0d %0d", disp3, disp2, disp1, disp0, hour_led, min_led, sec_led, mode);
        end
        rst = 1'b1;
        cyc(150);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        cyc(20);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            total++;
            if (obs_w !== exp_w) begin bad++; $display("FAIL reset_hold: got %h want %h", obs_w, exp_w); end
        end
        total++;
        if ({hour_led, min_led, sec_led, mode, disp0} !== {5'd0, 6'd0, 6'd0, 3'd0, 7'h40}) begin
            bad++; $display("FAIL reset_mid: got %0d:%0d:%0d mode %0d disp0 %h want zeros", hour_led, min_led, sec_led, mode, disp0);
        end
    endtask

    task automatic test_run_count();
        rst = 1'b1;
        for (int i = 0; i < 6001; i++) begin
            cyc(1);
            total++;
            if (obs_w !== exp_w) begin bad++; $display("FAIL run_count cyc %0d: got %h want %h", i, obs_w, exp_w); end
        end
        total++;
        if (min_led !== 6'd1 || sec_led !== 6'd0 || disp0 !== 7'h79) begin
            bad++; $display("FAIL run_minute: got min %0d sec %0d disp0 %h want 1 0 79", min_led, sec_led, disp0);
        end
    endtask

    task automatic test_rollover();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (59) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (59) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (HOUR_MAX - 1) press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NM && m_mode != 0; k++) press(1'b1, 1'b0, 1'b0);
        cyc(99);
        total++;
        if (obs_w !== exp_w) begin bad++; $display("FAIL rollover_pre: got %h want %h", obs_w, exp_w); end
        total++;
        if (hour_led !== 5'(HOUR_MAX - 1) || min_led !== 6'd59 || sec_led !== 6'd59) begin
            bad++; $display("FAIL rollover_set: got %0d:%0d:%0d want %0d:59:59", hour_led, min_led, sec_led, HOUR_MAX - 1);
        end
        cyc(2);
        total++;
        if (hour_led !== 5'd0 || min_led !== 6'd0 || sec_led !== 6'd0 || obs_w !== exp_w) begin
            bad++; $display("FAIL rollover_wrap: got %0d:%0d:%0d want 0:0:0", hour_led, min_led, sec_led);
        end
    endtask

    task automatic test_blink();
        logic [5:0] v;
        cyc(130);
        press(1'b1, 1'b0, 1'b0);
        v = 6'(m_t % 60);
        total++;
        if (mode !== 3'd1) begin bad++; $display("FAIL blink_mode: got %0d want 1", mode); end
        for (int i = 0; i < 54; i++) begin
            cyc(1);
            total++;
            if (obs_w !== exp_w) begin bad++; $display("FAIL blink_track: got %h want %h", obs_w, exp_w); end
        end
        total++;
        if (sec_led !== 6'd0 || disp1 !== 7'h7F || disp0 !== 7'h7F) begin
            bad++; $display("FAIL blink_blank: got sec %0d disp1 %h disp0 %h want 0 7f 7f", sec_led, disp1, disp0);
        end
        mask4sim = 1'b1;
        cyc(1);
        total++;
        if (sec_led !== v || obs_w !== exp_w) begin bad++; $display("FAIL blink_mask: got sec %0d want %0d", sec_led, v); end
        mask4sim = 1'b0;
        cyc(50);
        total++;
        if (sec_led !== v || obs_w !== exp_w) begin bad++; $display("FAIL blink_frozen: got sec %0d want %0d", sec_led, v); end
    endtask

    task automatic test_field_wrap();
        logic [4:0] h0;
        mask4sim = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        h0 = 5'(m_t / 3600);
        repeat (60) press(1'b0, 1'b1, 1'b0);
        cyc(1);
        total++;
        if (min_led !== 6'd0 || hour_led !== h0 || obs_w !== exp_w) begin
            bad++; $display("FAIL min_wrap: got min %0d hour %0d want 0 %0d", min_led, hour_led, h0);
        end
        press(1'b1, 1'b1, 1'b0);
        total++;
        if (mode !== 3'd3) begin bad++; $display("FAIL priority_mode: got %0d want 3", mode); end
        cyc(1);
        total++;
        if (hour_led !== h0 || obs_w !== exp_w) begin bad++; $display("FAIL priority_hour: got %0d want %0d", hour_led, h0); end
        for (int k = 0; k < NM && m_mode != 0; k++) press(1'b1, 1'b0, 1'b0);
        mask4sim = 1'b0;
    endtask

    task automatic test_page();
        cyc(37);
        for (int j = 0; j < 2; j++) begin
            press(1'b0, 1'b0, 1'b1);
            cyc(1);
            total++;
            if (obs_w !== exp_w) begin bad++; $display("FAIL page_toggle %0d: got %h want %h", j, obs_w, exp_w); end
            for (int i = 0; i < 150; i++) begin
                cyc(1);
                total++;
                if (obs_w !== exp_w) begin bad++; $display("FAIL page_run %0d: got %h want %h", j, obs_w, exp_w); end
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) btnl = 1'b1;
            else if (r < 6) btnu = 1'b1;
            else if (r < 8) btnr = 1'b1;
            else if (r < 9) btnl = 1'b1;
            if ($urandom_range(0, 99) == 0) mask4sim = ~mask4sim;
            if ($urandom_range(0, 1499) == 0) rst = 1'b0;
            else rst = 1'b1;
            cyc(1);
            total++;
            if (obs_w !== exp_w) begin bad++; $display("FAIL random cyc %0d: got %h want %h", i, obs_w, exp_w); end
        end
        rst = 1'b1;
        mask4sim = 1'b0;
    endtask

`ifdef CLOCK_HMS_ALARM_EN
    task automatic test_alarm();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        repeat (5) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        cyc(5999);
        total++;
        if (alarm !== 1'b0 || obs_w !== exp_w) begin bad++; $display("FAIL alarm_early: got %b want 0", alarm); end
        cyc(1);
        total++;
        if (alarm !== 1'b1 || obs_w !== exp_w) begin bad++; $display("FAIL alarm_fire: got %b want 1", alarm); end
        press(1'b0, 1'b1, 1'b0);
        total++;
        if (alarm !== 1'b0 || obs_w !== exp_w) begin bad++; $display("FAIL alarm_clear: got %b want 0", alarm); end
    endtask
`endif

    initial begin
        test_reset();
        test_run_count();
        test_rollover();
        test_blink();
        test_field_wrap();
        test_page();
        test_random();
`ifdef CLOCK_HMS_ALARM_EN
        test_alarm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_hms_gen.md
Name: clock_hms_gen

Overview:
Parametrised successor of the 24-hour display clock. It keeps hours, minutes and seconds counters with a configurable hour modulus and tick rate. The time is set through a field-select state machine with blinking of the field being edited, and shows on four active-low 7-segment digits with a selectable HH:MM or MM:SS page. It sits between the board button one-shot pulsers and the display/LED drivers.

Parameters:
CLK_HZ, 100000000, clk frequency; one real-time second = CLK_HZ cycles
SIM_DIV, 100, cycles per second tick when en4sim=1 (must be even, >=2)
HOUR_MAX, 24, hour modulus; legal values 12 or 24; hours count 0..HOUR_MAX-1
BLINK_HZ, 2, blink rate; half-period = CLK_HZ/(2*BLINK_HZ) cycles, or SIM_DIV/2 when en4sim=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
btnr  in  1  one-cycle pulse: page toggle (RUN) / clear field (set states)
btnl  in  1  one-cycle pulse: advance mode
btnu  in  1  one-cycle pulse: increment selected field
en4sim  in  1  1 = use SIM_DIV tick and SIM_DIV/2 blink half-period
mask4sim  in  1  1 = suppress blink blanking
disp3..disp0  out  7 each  segment data, active low, bit order gfedcba
hour_led  out  5  binary hours
min_led  out  6  binary minutes
sec_led  out  6  binary seconds
mode  out  3  0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR (4/5 with alarm)

Behaviour:
- Reset (rst=0 at posedge): hour/min/sec=0, prescaler=0, mode=RUN, page=0, blink phase=0. Outputs: leds 0, mode 0, all disp = 7'b1000000 ("0").
- Prescaler counts 0..DIV-1, where DIV = en4sim ? SIM_DIV : CLK_HZ; width $clog2(CLK_HZ). The tick pulse fires on the cycle the count equals DIV-1, then the count wraps to 0.
- RUN: on tick, sec increments. sec 59->0 carries into min; min 59->0 carries into hour; hour HOUR_MAX-1 -> 0.
- Mode FSM on btnl: RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN.
- In set states, time is frozen and the prescaler is held at 0. Returning to RUN restarts the prescaler from 0, so the first tick comes DIV cycles later.
- Set states, btnu: selected field +1 modulo its range (60, 60, HOUR_MAX). No carry into other fields.
- Set states, btnr: selected field cleared to 0.
- RUN, btnr: toggles page (0 = HH:MM, 1 = MM:SS).
- Page forcing: SET_SEC displays page 1; SET_HOUR displays page 0; SET_MIN uses the current page. The page register itself is not modified.
- Button priority within one cycle: btnl > btnu > btnr. Only the highest-priority button acts.
- A tick in the same cycle as btnl in RUN: the tick is applied and the mode advances.
- Blink: the phase toggles every half-period in set states and is forced to 0 on every mode change.
  - When phase=1 and mask4sim=0, the selected field's two digits are driven to 7'h7F and its led vector to 0.
  - Counters are unaffected by blinking.
- Display digits: page 0: disp3/disp2 = hour tens/ones, disp1/disp0 = min tens/ones. Page 1: disp3/disp2 = min, disp1/disp0 = sec.
- Segment codes, 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- All outputs are registered. Displays and leds follow counter updates by exactly 1 cycle.
- Reset asserted mid-operation, in any mode: the full reset state is restored on the next posedge.

Optional Feature:
CLOCK_HMS_ALARM_EN:
- Defined:
  - Adds alarm_hour/alarm_min registers (reset 0) and output port alarm (1 bit, reset 0).
  - Mode sequence becomes SET_HOUR -> SET_ALM_HOUR(4) -> SET_ALM_MIN(5) -> RUN. These states display alarm HH:MM with blinking and accept btnu/btnr the same way as the time set states.
  - alarm goes to 1 on the RUN tick that yields sec=0 with hour:min equal to the alarm time. It clears on any button pulse or on the next minute change.
- Not defined: alarm registers, alarm port and modes 4/5 are absent.

Test Plan:
1. rst=0 for 3 cycles -> all disp=7'h40, leds=0, mode=0; rst held low for 5 cycles with ticks pending -> still all zero.
2. en4sim=1, 6000 cycles after reset release -> min_led=1, sec_led=0, disp0=7'h79.
3. Set 23:59:59 via btnl/btnu, return to RUN, wait 100 cycles -> hour=min=sec=0; with HOUR_MAX=12, 11:59:59 -> 00:00:00.
4. btnl once -> mode=1, sec frozen; sec_led alternates 0 / value every 50 cycles, disp1/disp0=7'h7F in the blank phase; mask4sim=1 -> no blanking.
5. SET_MIN, 60 btnu pulses from min=0 -> min=0, hour unchanged; btnl+btnu in the same cycle -> only the mode advances.
6. RUN, btnr -> disp shows MM:SS next cycle; second btnr -> HH:MM; with CLOCK_HMS_ALARM_EN and alarm 00:01, alarm=1 at cycle 6000 after start, cleared by btnu.
